// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: stage enables, flushes, stalls, DMEM freeze
//
// Purpose:
//   Drives the per-stage register enables and flushes of the 5-stage core.
//   Holds the core idle for BOOT_CYC cycles after reset. Then it resolves
//   DMEM wait-state freezes, taken-branch redirects and load-use stalls, in
//   that priority order. A DMEM access that never acks is abandoned after
//   TIMEOUT wait cycles and flagged in a sticky error bit.
//
// Ports:
//   clk, rst_n              core clock (rising edge), async active-low reset
//   d_addr1/2, d_use1/2     DECODE source registers and their use flags
//   d_mem_write             DECODE instruction is a store
//   e_waddr, e_mem_read     EXECUTE destination register, EXECUTE is a load
//   e_br_taken              EXECUTE resolved a taken branch/jump
//   m_mem_req, m_mem_ack    MEMORY stage DMEM request / completion
//   pc_en, fd_en, de_en,
//   em_en, mw_en            PC and pipeline register load enables
//   fd_flush, de_flush      IF/ID -> NOP, ID/EX -> bubble
//   mem_err                 sticky DMEM timeout flag
//   lu_cnt, mw_cnt          saturating load-use stall / DMEM wait counters
module pipe_ctrl #(
    parameter int BOOT_CYC = 4,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_addr1,
    input  logic [4:0]       d_addr2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             d_mem_write,
    input  logic [4:0]       e_waddr,
    input  logic             e_mem_read,
    input  logic             e_br_taken,
    input  logic             m_mem_req,
    input  logic             m_mem_ack,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_en,
    output logic             de_flush,
    output logic             em_en,
    output logic             mw_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mw_cnt
);

    localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WW-1:0]    wait_nxt;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;

    logic freeze;
    logic lu_hit;

    // A store's rs2 only feeds DMEM write data, which is forwarded at MEM,
    // so a match on it does not need the one-cycle load-use bubble.
    assign lu_hit = e_mem_read && (e_waddr != 5'd0) &&
                    ((d_use1 && (d_addr1 == e_waddr)) ||
                     (d_use2 && (d_addr2 == e_waddr) && !d_mem_write));

    // Same-cycle ack is a zero-wait access and never freezes.
    assign freeze = m_mem_req && !m_mem_ack;

    assign wait_nxt = wait_cnt_q + WW'(1);

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        lu_cnt_d   = lu_cnt_q;
        mw_cnt_d   = mw_cnt_q;
        pc_en      = 1'b0;
        fd_en      = 1'b0;
        de_en      = 1'b0;
        em_en      = 1'b0;
        mw_en      = 1'b0;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end

            ST_RUN: begin
                pc_en = 1'b1;
                fd_en = 1'b1;
                de_en = 1'b1;
                em_en = 1'b1;
                mw_en = 1'b1;
                if (freeze) begin
                    pc_en      = 1'b0;
                    fd_en      = 1'b0;
                    de_en      = 1'b0;
                    em_en      = 1'b0;
                    mw_en      = 1'b0;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (e_br_taken) begin
                    // The DECODE instruction is wrong-path, so a pending
                    // load-use stall on it is moot.
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                end else if (lu_hit) begin
                    // One bubble suffices: the load moves on to MEM next cycle.
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_flush = 1'b1;
                    if (lu_cnt_q != '1) begin
                        lu_cnt_d = lu_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (mw_cnt_q != '1) begin
                    mw_cnt_d = mw_cnt_q + CNT_W'(1);
                end
                if (m_mem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_nxt == WAIT_LAST) begin
                    // Abandon the access and let the pipeline resume.
                    mem_err_d  = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_nxt;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            lu_cnt_q   <= '0;
            mw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            lu_cnt_q   <= lu_cnt_d;
            mw_cnt_q   <= mw_cnt_d;
        end
    end

    assign mem_err = mem_err_q;
    assign lu_cnt  = lu_cnt_q;
    assign mw_cnt  = mw_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    d_addr1, d_addr2, e_waddr;
    logic          d_use1, d_use2, d_mem_write;
    logic          e_mem_read, e_br_taken, m_mem_req, m_mem_ack;
    logic          pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mem_err;
    logic [CW-1:0] lu_cnt, mw_cnt;
    logic [6:0]    outs;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.BOOT_CYC(4), .TIMEOUT(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_addr1(d_addr1), .d_addr2(d_addr2), .d_use1(d_use1), .d_use2(d_use2),
        .d_mem_write(d_mem_write), .e_waddr(e_waddr), .e_mem_read(e_mem_read),
        .e_br_taken(e_br_taken), .m_mem_req(m_mem_req), .m_mem_ack(m_mem_ack),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en),
        .de_flush(de_flush), .em_en(em_en), .mw_en(mw_en), .mem_err(mem_err),
        .lu_cnt(lu_cnt), .mw_cnt(mw_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush}
    assign outs = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush};

    localparam logic [6:0] O_RUN    = 7'b1111100;
    localparam logic [6:0] O_STALL  = 7'b0011101;
    localparam logic [6:0] O_REDIR  = 7'b1111111;
    localparam logic [6:0] O_FROZEN = 7'b0000000;
    localparam logic [6:0] O_BOOT   = 7'b0000011;

    typedef struct {
        logic [4:0] a1, a2, ew;
        logic       u1, u2, st, emr, br, req, ack;
        logic [6:0] exp_o;
        logic       inc;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic u1, input logic u2, input logic st,
                                input logic [4:0] ew, input logic emr,
                                input logic br, input logic req, input logic ack,
                                input logic [6:0] exp_o, input logic inc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.u1 = u1; v.u2 = u2; v.st = st; v.ew = ew;
        v.emr = emr; v.br = br; v.req = req; v.ack = ack;
        v.exp_o = exp_o; v.inc = inc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        d_addr1 = 0; d_addr2 = 0; d_use1 = 0; d_use2 = 0; d_mem_write = 0;
        e_waddr = 0; e_mem_read = 0; e_br_taken = 0; m_mem_req = 0; m_mem_ack = 0;
    endtask

    task automatic drive(input vec_t v);
        d_addr1 = v.a1; d_addr2 = v.a2; d_use1 = v.u1; d_use2 = v.u2;
        d_mem_write = v.st; e_waddr = v.ew; e_mem_read = v.emr;
        e_br_taken = v.br; m_mem_req = v.req; m_mem_ack = v.ack;
    endtask

    // Reset, then release; with do_chk the boot interval is verified.
    task automatic do_reset(input bit do_chk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (do_chk) begin
            chk("reset_outs", 32'(outs), 32'(O_BOOT));
            chk("reset_cnts", 32'({mem_err, lu_cnt, mw_cnt}), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (do_chk) chk($sformatf("boot_cyc%0d", i + 1), 32'(outs), 32'(O_BOOT));
            @(negedge clk);
        end
        #1;
        if (do_chk) chk("boot_cyc5_run", 32'(outs), 32'(O_RUN));
    endtask

    initial begin
        int exp_lu;
        rst_n = 1'b0;
        idle_inputs();

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   0); // idle
        vecs[1]  = mk(5, 1, 1, 1, 0, 5, 1, 0, 0, 0, O_STALL, 1); // lw x5; add x6,x5,x1
        vecs[2]  = mk(2, 5, 1, 1, 1, 5, 1, 0, 0, 0, O_RUN,   0); // lw x5; sw x5,0(x2)
        vecs[3]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, O_RUN,   0); // load to x0
        vecs[4]  = mk(5, 1, 1, 1, 0, 5, 1, 1, 0, 0, O_REDIR, 0); // branch beats load-use
        vecs[5]  = mk(3, 7, 1, 1, 0, 7, 1, 0, 0, 0, O_STALL, 1); // rs2 hit, non-store
        vecs[6]  = mk(5, 5, 0, 0, 0, 5, 1, 0, 0, 0, O_RUN,   0); // match but unused
        vecs[7]  = mk(5, 1, 1, 1, 0, 5, 0, 0, 0, 0, O_RUN,   0); // not a load
        vecs[8]  = mk(5, 1, 1, 1, 0, 5, 1, 0, 1, 1, O_STALL, 1); // zero-wait DMEM + stall
        vecs[9]  = mk(5, 2, 1, 1, 1, 5, 1, 0, 0, 0, O_STALL, 1); // store rs1 hit, saturates
        vecs[10] = mk(1, 9, 0, 1, 0, 9, 1, 0, 0, 0, O_STALL, 1); // stays saturated
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_REDIR, 0); // plain redirect

        do_reset(1'b1);

        exp_lu = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_o));
            @(posedge clk);
            #1;
            if (vecs[i].inc && exp_lu < 3) exp_lu++;
            chk($sformatf("vec%0d_lu_cnt", i), 32'(lu_cnt), 32'(exp_lu));
        end

        // DMEM ack after 3 wait cycles, with a redirect held by frozen EXECUTE.
        do_reset(1'b0);
        @(negedge clk);
        m_mem_req = 1; e_br_taken = 1;
        #1 chk("freeze_run_cycle", 32'(outs), 32'(O_FROZEN));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            m_mem_req = 0;
            m_mem_ack = (i == 3);
            #1 chk($sformatf("mem_wait%0d", i), 32'(outs), 32'(O_FROZEN));
        end
        @(negedge clk);
        m_mem_ack = 0;
        #1;
        chk("post_wait_redirect", 32'(outs), 32'(O_REDIR));
        chk("mw_cnt_ack3", 32'(mw_cnt), 32'd3);
        chk("mem_err_after_ack", 32'(mem_err), 32'd0);

        // Asynchronous reset in the middle of MEM_WAIT.
        @(negedge clk);
        e_br_taken = 0; m_mem_req = 1;
        @(negedge clk);
        m_mem_req = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs), 32'(O_BOOT));
        chk("async_rst_cnts", 32'({mem_err, lu_cnt, mw_cnt}), 32'd0);

        // Timeout: no ack for 8 wait cycles.
        do_reset(1'b0);
        @(negedge clk);
        m_mem_req = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            m_mem_req = 0;
            #1;
            chk($sformatf("to_wait%0d_outs", i), 32'(outs), 32'(O_FROZEN));
            chk($sformatf("to_wait%0d_err", i), 32'(mem_err), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("timeout_err", 32'(mem_err), 32'd1);
        chk("timeout_run", 32'(outs), 32'(O_RUN));
        chk("mw_cnt_saturated", 32'(mw_cnt), 32'd3);
        repeat (3) @(negedge clk);
        #1 chk("mem_err_sticky", 32'(mem_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
